// File: rtl/arithmetic_core_param.sv
// Pipelined K*K-tap signed MAC with bias, rounded requantisation, saturation,
// optional ReLU and optional streaming max-pool. Config rides with each sample.
module arithmetic_core_param #(
    parameter int unsigned DATA_W  = 8,
    parameter int unsigned TAPS    = 9,
    parameter int unsigned BIAS_W  = 16,
    parameter int unsigned SHIFT_W = 3,
    parameter int unsigned POOL    = 2,
    parameter int unsigned ACC_W   = 2 * DATA_W + $clog2(TAPS) + 1
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [TAPS*DATA_W-1:0]     in_data,
    input  logic [TAPS*DATA_W-1:0]     weight,
    input  logic [BIAS_W-1:0]          bias,
    input  logic [SHIFT_W-1:0]         bound_level,
    input  logic                       en,
    input  logic                       en_relu,
    input  logic                       en_mp,
    output logic signed [DATA_W-1:0]   out,
    output logic                       out_en
);

    localparam int unsigned PROD_W = 2 * DATA_W;
    localparam int unsigned RND_W  = ACC_W + 1;
    localparam int unsigned CNT_W  = (POOL > 1) ? $clog2(POOL) : 1;

    localparam logic signed [RND_W-1:0] SAT_MAX = RND_W'((2 ** (DATA_W - 1)) - 1);
    localparam logic signed [RND_W-1:0] SAT_MIN = ~SAT_MAX;

    // ---------------- stage 1: per-tap products ----------------
    logic signed [DATA_W-1:0]  px_c   [TAPS];
    logic signed [DATA_W-1:0]  wt_c   [TAPS];
    logic signed [PROD_W-1:0]  prod_c [TAPS];

    logic signed [PROD_W-1:0]  prod_q [TAPS];
    logic signed [BIAS_W-1:0]  bias1_q;
    logic [SHIFT_W-1:0]        shift1_q;
    logic                      relu1_q;
    logic                      mp1_q;
    logic                      v1_q;

    // Tap 0 sits in the MSBs of both window and weight buses.
    always_comb begin
        for (int i = 0; i < TAPS; i++) begin
            px_c[i]   = in_data[(TAPS-1-i)*DATA_W +: DATA_W];
            wt_c[i]   = weight[(TAPS-1-i)*DATA_W +: DATA_W];
            prod_c[i] = PROD_W'(px_c[i]) * PROD_W'(wt_c[i]);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < TAPS; i++) prod_q[i] <= '0;
            bias1_q  <= '0;
            shift1_q <= '0;
            relu1_q  <= 1'b0;
            mp1_q    <= 1'b0;
            v1_q     <= 1'b0;
        end else begin
            v1_q <= en;
            if (en) begin
                for (int i = 0; i < TAPS; i++) prod_q[i] <= prod_c[i];
                bias1_q  <= bias;
                shift1_q <= bound_level;
                relu1_q  <= en_relu;
                mp1_q    <= en_mp;
            end
        end
    end

    // ---------------- stage 2: accumulate plus bias ----------------
    logic signed [ACC_W-1:0]   acc_c;
    logic signed [ACC_W-1:0]   acc2_q;
    logic [SHIFT_W-1:0]        shift2_q;
    logic                      relu2_q;
    logic                      mp2_q;
    logic                      v2_q;

    always_comb begin
        acc_c = ACC_W'(bias1_q);
        for (int i = 0; i < TAPS; i++) begin
            acc_c = acc_c + ACC_W'(prod_q[i]);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc2_q   <= '0;
            shift2_q <= '0;
            relu2_q  <= 1'b0;
            mp2_q    <= 1'b0;
            v2_q     <= 1'b0;
        end else begin
            v2_q <= v1_q;
            if (v1_q) begin
                acc2_q   <= acc_c;
                shift2_q <= shift1_q;
                relu2_q  <= relu1_q;
                mp2_q    <= mp1_q;
            end
        end
    end

    // ---------------- stage 3: round, shift, saturate, ReLU ----------------
    logic signed [RND_W-1:0]   rnd_half_c;
    logic signed [RND_W-1:0]   rnd_sum_c;
    logic signed [RND_W-1:0]   rnd_sh_c;
    logic signed [DATA_W-1:0]  res_c;

    logic signed [DATA_W-1:0]  res3_q;
    logic                      mp3_q;
    logic                      v3_q;

    // One extra bit of headroom keeps the half-LSB add from wrapping.
    always_comb begin
        rnd_half_c = '0;
        if (shift2_q != '0) begin
            rnd_half_c = RND_W'(1) << (shift2_q - SHIFT_W'(1));
        end
        rnd_sum_c = RND_W'(acc2_q) + rnd_half_c;
        rnd_sh_c  = rnd_sum_c >>> shift2_q;
        if (rnd_sh_c > SAT_MAX) begin
            res_c = DATA_W'(SAT_MAX);
        end else if (rnd_sh_c < SAT_MIN) begin
            res_c = DATA_W'(SAT_MIN);
        end else begin
            res_c = DATA_W'(rnd_sh_c);
        end
        if (relu2_q && res_c[DATA_W-1]) begin
            res_c = '0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            res3_q <= '0;
            mp3_q  <= 1'b0;
            v3_q   <= 1'b0;
        end else begin
            v3_q <= v2_q;
            if (v2_q) begin
                res3_q <= res_c;
                mp3_q  <= mp2_q;
            end
        end
    end

    // ---------------- output stage: bypass or streaming max-pool ----------------
    logic [CNT_W-1:0]          pool_cnt_q;
    logic signed [DATA_W-1:0]  pool_max_q;
    logic signed [DATA_W-1:0]  pool_cand_c;
    logic                      pool_last_c;

    always_comb begin
        pool_cand_c = res3_q;
        if (pool_cnt_q != '0 && pool_max_q > res3_q) begin
            pool_cand_c = pool_max_q;
        end
        pool_last_c = (pool_cnt_q == CNT_W'(POOL - 1));
    end

    // A bypass sample resets the counter, so any partial group is dropped.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out        <= '0;
            out_en     <= 1'b0;
            pool_cnt_q <= '0;
            pool_max_q <= '0;
        end else begin
            out_en <= 1'b0;
            if (v3_q) begin
                if (!mp3_q) begin
                    out        <= res3_q;
                    out_en     <= 1'b1;
                    pool_cnt_q <= '0;
                end else if (pool_last_c) begin
                    out        <= pool_cand_c;
                    out_en     <= 1'b1;
                    pool_cnt_q <= '0;
                end else begin
                    pool_max_q <= pool_cand_c;
                    pool_cnt_q <= pool_cnt_q + CNT_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_arithmetic_core_param.sv
// Randomised bench for arithmetic_core_param against a cycle-indexed
// behavioural model built from plain integer arithmetic and a pool queue.
module tb_arithmetic_core_param;

    localparam int DATA_W  = 8;
    localparam int TAPS    = 9;
    localparam int BIAS_W  = 16;
    localparam int SHIFT_W = 3;
    localparam int POOL    = 2;
    localparam int IW      = TAPS * DATA_W;

    logic                      clk = 1'b0;
    logic                      reset;
    logic [IW-1:0]             in_data;
    logic [IW-1:0]             weight;
    logic [BIAS_W-1:0]         bias;
    logic [SHIFT_W-1:0]        bound_level;
    logic                      en;
    logic                      en_relu;
    logic                      en_mp;
    logic signed [DATA_W-1:0]  dout;
    logic                      out_en;

    arithmetic_core_param #(
        .DATA_W(DATA_W), .TAPS(TAPS), .BIAS_W(BIAS_W),
        .SHIFT_W(SHIFT_W), .POOL(POOL)
    ) dut (
        .clk(clk), .reset(reset), .in_data(in_data), .weight(weight),
        .bias(bias), .bound_level(bound_level), .en(en), .en_relu(en_relu),
        .en_mp(en_mp), .out(dout), .out_en(out_en)
    );

    always #5 clk = ~clk;

    int a_v [TAPS];
    int w_v [TAPS];
    int bias_v;
    int s_v;
    bit relu_v;
    bit mp_v;

    int n_vec;
    int n_err;
    int cyc;
    bit exp_en [int];
    int exp_val [int];
    int model_out;
    bit model_en;
    int grp [$];

    // Reference: exact integer MAC, half-up rounding shift, clamp, ReLU.
    function automatic int ref_result();
        int acc;
        acc = bias_v;
        for (int i = 0; i < TAPS; i++) acc += a_v[i] * w_v[i];
        if (s_v > 0) acc = (acc + (1 << (s_v - 1))) >>> s_v;
        if (acc > 127) acc = 127;
        if (acc < -128) acc = -128;
        if (relu_v && acc < 0) acc = 0;
        return acc;
    endfunction

    task automatic emit(input int v);
        exp_en[cyc + 4]  = 1'b1;
        exp_val[cyc + 4] = v;
    endtask

    // Drive the next edge's inputs; a valid sample also updates the model.
    task automatic load(input bit en_i);
        int r;
        int m;
        en = en_i;
        if (en_i) begin
            for (int i = 0; i < TAPS; i++) begin
                in_data[(TAPS-1-i)*DATA_W +: DATA_W] = DATA_W'(a_v[i]);
                weight[(TAPS-1-i)*DATA_W +: DATA_W]  = DATA_W'(w_v[i]);
            end
            bias        = BIAS_W'(bias_v);
            bound_level = SHIFT_W'(s_v);
            en_relu     = relu_v;
            en_mp       = mp_v;
            r = ref_result();
            if (mp_v) begin
                grp.push_back(r);
                if (grp.size() == POOL) begin
                    m = grp[0];
                    foreach (grp[k]) if (grp[k] > m) m = grp[k];
                    emit(m);
                    grp.delete();
                end
            end else begin
                grp.delete();
                emit(r);
            end
        end else begin
            in_data     = IW'({$urandom(), $urandom(), $urandom()});
            weight      = IW'({$urandom(), $urandom(), $urandom()});
            bias        = BIAS_W'($urandom());
            bound_level = SHIFT_W'($urandom());
            en_relu     = 1'($urandom());
            en_mp       = 1'($urandom());
        end
    endtask

    task automatic tick();
        @(posedge clk);
        cyc++;
        #1;
        model_en = exp_en.exists(cyc);
        if (model_en) model_out = exp_val[cyc];
    endtask

    task automatic rand_window();
        for (int i = 0; i < TAPS; i++) begin
            a_v[i] = int'($urandom_range(255)) - 128;
            w_v[i] = int'($urandom_range(255)) - 128;
        end
        bias_v = int'($urandom_range(65535)) - 32768;
        s_v    = int'($urandom_range(7));
    endtask

    task automatic single_tap(input int v);
        for (int i = 0; i < TAPS; i++) begin
            a_v[i] = 0;
            w_v[i] = 0;
        end
        a_v[0] = v;
        w_v[0] = 1;
        bias_v = 0;
        s_v    = 0;
    endtask

    task automatic test_reset();
        n_vec++;
        if (out_en !== 1'b0 || dout !== 8'sd0) begin
            $display("FAIL reset_state: out=%0d out_en=%0b, want out=0 out_en=0", dout, out_en);
            n_err++;
        end
    endtask

    task automatic test_basic();
        for (int i = 0; i < TAPS; i++) begin
            a_v[i] = 1;
            w_v[i] = 1;
        end
        bias_v = 0; s_v = 0; relu_v = 0; mp_v = 0;
        for (int c = 0; c < 6; c++) begin
            load(c == 0);
            tick();
            n_vec++;
            if (out_en !== model_en || dout !== 8'(model_out)) begin
                $display("FAIL basic c%0d: out=%0d out_en=%0b, want out=%0d out_en=%0b", c, dout, out_en, model_out, model_en);
                n_err++;
            end
        end
        n_vec++;
        if (dout !== 8'sd9) begin
            $display("FAIL basic_value: out=%0d, want 9", dout);
            n_err++;
        end
    endtask

    task automatic test_saturation();
        for (int c = 0; c < 7; c++) begin
            for (int i = 0; i < TAPS; i++) begin
                a_v[i] = 127;
                w_v[i] = (c == 0) ? 127 : -128;
            end
            bias_v = 0; s_v = 0; mp_v = 0;
            relu_v = (c == 2);
            load(c < 3);
            tick();
            n_vec++;
            if (out_en !== model_en || dout !== 8'(model_out)) begin
                $display("FAIL saturation c%0d: out=%0d out_en=%0b, want out=%0d out_en=%0b", c, dout, out_en, model_out, model_en);
                n_err++;
            end
        end
    endtask

    task automatic test_rounding();
        for (int c = 0; c < 7; c++) begin
            relu_v = 0; mp_v = 0;
            case (c)
                0: begin single_tap(5);  s_v = 1; end
                1: begin single_tap(-5); s_v = 1; end
                default: begin single_tap(0); bias_v = -1; end
            endcase
            load(c < 3);
            tick();
            n_vec++;
            if (out_en !== model_en || dout !== 8'(model_out)) begin
                $display("FAIL rounding c%0d: out=%0d out_en=%0b, want out=%0d out_en=%0b", c, dout, out_en, model_out, model_en);
                n_err++;
            end
        end
    endtask

    task automatic test_back_to_back();
        int pulses;
        pulses = 0;
        for (int c = 0; c < 72; c++) begin
            rand_window();
            relu_v = 1'($urandom()); mp_v = 0;
            load(c < 64);
            tick();
            if (out_en === 1'b1) pulses++;
            n_vec++;
            if (out_en !== model_en || dout !== 8'(model_out)) begin
                $display("FAIL back_to_back c%0d: out=%0d out_en=%0b, want out=%0d out_en=%0b", c, dout, out_en, model_out, model_en);
                n_err++;
            end
        end
        n_vec++;
        if (pulses != 64) begin
            $display("FAIL back_to_back_count: pulses=%0d, want 64", pulses);
            n_err++;
        end
    endtask

    task automatic test_pool();
        int seq [8] = '{3, 7, -1, 5, 9, 4, -3, 0};
        for (int c = 0; c < 12; c++) begin
            relu_v = 0;
            if (c < 8) single_tap(seq[c]);
            mp_v = (c < 5);
            load(c < 7);
            tick();
            n_vec++;
            if (out_en !== model_en || dout !== 8'(model_out)) begin
                $display("FAIL pool c%0d: out=%0d out_en=%0b, want out=%0d out_en=%0b", c, dout, out_en, model_out, model_en);
                n_err++;
            end
        end
    endtask

    task automatic test_reset_midstream();
        for (int c = 0; c < 3; c++) begin
            rand_window();
            relu_v = 0; mp_v = (c == 0);
            load(1'b1);
            tick();
        end
        reset = 1'b1;
        #1;
        foreach (exp_en[k]) if (k > cyc) begin
            exp_en.delete(k);
            exp_val.delete(k);
        end
        grp.delete();
        model_out = 0;
        model_en  = 1'b0;
        n_vec++;
        if (out_en !== 1'b0 || dout !== 8'sd0) begin
            $display("FAIL reset_async: out=%0d out_en=%0b, want out=0 out_en=0", dout, out_en);
            n_err++;
        end
        load(1'b0);
        tick();
        reset = 1'b0;
        for (int c = 0; c < 9; c++) begin
            rand_window();
            relu_v = 0; mp_v = 0;
            load(c == 3);
            tick();
            n_vec++;
            if (out_en !== model_en || dout !== 8'(model_out)) begin
                $display("FAIL reset_mid c%0d: out=%0d out_en=%0b, want out=%0d out_en=%0b", c, dout, out_en, model_out, model_en);
                n_err++;
            end
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 300; c++) begin
            rand_window();
            relu_v = 1'($urandom());
            mp_v   = ($urandom_range(3) != 0);
            load($urandom_range(9) < 7 && c < 295);
            tick();
            n_vec++;
            if (out_en !== model_en || dout !== 8'(model_out)) begin
                $display("FAIL random c%0d: out=%0d out_en=%0b, want out=%0d out_en=%0b", c, dout, out_en, model_out, model_en);
                n_err++;
            end
        end
    endtask

    initial begin
        n_vec = 0; n_err = 0; cyc = 0;
        model_out = 0; model_en = 1'b0;
        reset = 1'b1;
        en = 1'b0; en_relu = 1'b0; en_mp = 1'b0;
        in_data = '0; weight = '0; bias = '0; bound_level = '0;
        #12;
        test_reset();
        reset = 1'b0;
        test_basic();
        test_saturation();
        test_rounding();
        test_back_to_back();
        test_pool();
        test_reset_midstream();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
